ysyx_220053_mem_arbiter: RTL and testbench

- Shares one 64-bit memory port between the instruction-fetch unit (IF master) and the load/store unit (LS master).
- Sits between the IFU/LSU and the memory model or bus bridge.
- Accepts one transaction at a time and registers the memory response back to its owner.
- Fixed LS-over-IF priority, with a starvation guard that guarantees forward progress for instruction fetch.

---
 rtl/ysyx_220053_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_ysyx_220053_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220053_mem_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store.
// LS has priority. A run counter caps how many LS grants in a row can pass a waiting IF.
module ysyx_220053_mem_arbiter #(
  parameter int unsigned AW         = 64,
  parameter int unsigned DW         = 64,
  parameter int unsigned LS_MAX_RUN = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rdata,

  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_wen,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_rsp_valid,
  output logic [DW-1:0]   ls_rdata,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rdata,

  output logic            busy
);

  localparam int unsigned MW     = DW / 8;
  localparam logic [3:0]  MaxRun = 4'(LS_MAX_RUN);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;  // 1: LS owns the transaction, 0: IF
  logic [3:0]      run_q, run_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
  logic            grant_ls, grant_if;

  // LS wins unless IF is waiting and LS has used up its run budget.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state_q == StIdle) begin
      grant_ls = ls_req_valid && !(if_req_valid && (run_q == MaxRun));
      grant_if = if_req_valid && !grant_ls;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    run_d      = run_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ls) begin
          owner_d = 1'b1;
          addr_d  = ls_addr;
          wen_d   = ls_wen;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
          state_d = StReq;
          if (if_req_valid) begin
            run_d = (run_q == MaxRun) ? run_q : run_q + 4'd1;
          end else begin
            run_d = 4'd0;
          end
        end else if (grant_if) begin
          owner_d = 1'b0;
          addr_d  = if_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          run_d   = 4'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_rsp_valid) begin
          if (owner_q) ls_rdata_d = mem_rdata;
          else         if_rdata_d = mem_rdata;
          state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      run_q      <= 4'd0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      run_q      <= run_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Readies are masked during reset so every output reads 0 while rst is high.
  assign if_req_ready  = grant_if && !rst;
  assign ls_req_ready  = grant_ls && !rst;
  assign mem_req_valid = (state_q == StReq);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_rsp_valid  = (state_q == StResp) && !owner_q;
  assign ls_rsp_valid  = (state_q == StResp) && owner_q;
  assign if_rdata      = if_rdata_q;
  assign ls_rdata      = ls_rdata_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Self-checking bench for the IF/LS memory arbiter: vector table plus corner sequences,
// with a response scoreboard filled at accept time and drained on rsp_valid pulses.
module tb_ysyx_220053_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        busy;

  ysyx_220053_mem_arbiter #(.AW(64), .DW(64), .LS_MAX_RUN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_addr       (ls_addr),
    .ls_wen        (ls_wen),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rdata      (ls_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ls;
    logic [63:0] addr;
    bit          wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          stall;
    int          lat;
    logic [63:0] rsp_data;
    bit          stray;
  } vec_t;

  typedef struct {
    bit          is_ls;
    logic [63:0] data;
  } sb_t;

  sb_t         sb[$];
  int          nchecks = 0;
  int          nerrors = 0;
  logic [63:0] last_if = '0;
  logic [63:0] last_ls = '0;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drains the scoreboard on every response pulse.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst && (if_rsp_valid || ls_rsp_valid)) begin
        if (sb.size() == 0) begin
          nchecks++;
          nerrors++;
          $display("FAIL unexpected_rsp: got if=%b ls=%b expected none", if_rsp_valid,
                   ls_rsp_valid);
        end else begin
          e = sb.pop_front();
          check("rsp_both", {63'd0, if_rsp_valid & ls_rsp_valid}, 64'd0);
          check("rsp_owner", {63'd0, ls_rsp_valid}, {63'd0, e.is_ls});
          if (e.is_ls) begin
            check("ls_rdata", ls_rdata, e.data);
            check("if_rdata_hold", if_rdata, last_if);
            last_ls = e.data;
          end else begin
            check("if_rdata", if_rdata, e.data);
            check("ls_rdata_hold", ls_rdata, last_ls);
            last_if = e.data;
          end
        end
      end
    end
  end

  // One complete transaction. Ends at the negedge of the RESP cycle.
  task automatic run_txn(input vec_t v, input bit other_valid, input bit sync, input int max_wait);
    int          n;
    logic        got;
    logic        exp_wen;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
    sb_t         e;
    if (sync) @(negedge clk);
    if (v.is_ls) begin
      ls_req_valid = 1'b1;
      ls_addr      = v.addr;
      ls_wen       = v.wen;
      ls_wdata     = v.wdata;
      ls_wmask     = v.wmask;
      if_req_valid = other_valid;
    end else begin
      if_req_valid = 1'b1;
      if_addr      = v.addr;
      ls_req_valid = other_valid;
    end
    #1;
    n = 0;
    while (!(v.is_ls ? ls_req_ready : if_req_ready) && n < max_wait) begin
      @(negedge clk);
      #1;
      n++;
    end
    got = v.is_ls ? ls_req_ready : if_req_ready;
    check("grant", {63'd0, got}, 64'd1);
    if (!got) begin
      if (v.is_ls) ls_req_valid = 1'b0;
      else         if_req_valid = 1'b0;
      return;
    end
    check("other_ready", {63'd0, v.is_ls ? if_req_ready : ls_req_ready}, 64'd0);
    check("busy_idle", {63'd0, busy}, 64'd0);
    e.is_ls = v.is_ls;
    e.data  = v.rsp_data;
    sb.push_back(e);
    exp_wen   = v.is_ls ? v.wen   : 1'b0;
    exp_wdata = v.is_ls ? v.wdata : 64'd0;
    exp_wmask = v.is_ls ? v.wmask : 8'd0;
    @(posedge clk);
    #1;
    if (v.is_ls) ls_req_valid = 1'b0;
    else         if_req_valid = 1'b0;
    mem_rsp_valid = v.stray;
    mem_rdata     = ~v.rsp_data;
    for (int s = 0; s <= v.stall; s++) begin
      @(negedge clk);
      check("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
      check("mem_addr", mem_addr, v.addr);
      check("mem_wen", {63'd0, mem_wen}, {63'd0, exp_wen});
      check("mem_wdata", mem_wdata, exp_wdata);
      check("mem_wmask", {56'd0, mem_wmask}, {56'd0, exp_wmask});
      check("ready_busy", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
      mem_req_ready = (s == v.stall);
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
    end
    mem_rsp_valid = 1'b0;
    for (int l = 0; l < v.lat; l++) begin
      @(negedge clk);
      check("wait_no_req", {63'd0, mem_req_valid}, 64'd0);
    end
    @(negedge clk);
    check("wait_no_req", {63'd0, mem_req_valid}, 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = v.rsp_data;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'h5a5a_5a5a_5a5a_5a5a;
    @(negedge clk);
    check("rsp_mine", {63'd0, v.is_ls ? ls_rsp_valid : if_rsp_valid}, 64'd1);
    check("rsp_other", {63'd0, v.is_ls ? if_rsp_valid : ls_rsp_valid}, 64'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{0, 64'h8000_0000, 0, 64'd0, 8'h00, 0, 0, 64'h0000_0013, 0};
    vecs[1] = '{1, 64'h8000_2000, 1, 64'hDEAD_BEEF, 8'h0F, 3, 1, 64'h0000_55AA, 0};
    vecs[2] = '{1, 64'h8000_1008, 0, 64'h1, 8'h00, 1, 2, 64'h1122_3344_5566_7788, 0};
    vecs[3] = '{0, 64'h8000_0008, 0, 64'd0, 8'h00, 0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[4] = '{1, 64'h8000_2010, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 64'h77, 0};
    vecs[5] = '{0, 64'h8000_000C, 0, 64'd0, 8'h00, 2, 0, 64'h0000_CAFE, 1};

    rst = 1'b1;
    if_req_valid = 1'b1; if_addr = 64'h1234;
    ls_req_valid = 1'b1; ls_addr = 64'h5678; ls_wen = 1'b1;
    ls_wdata = 64'hFFFF; ls_wmask = 8'hFF;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req_valid}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_rsp", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
    check("rst_rdata", if_rdata | ls_rdata, 64'd0);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i], 1'b0, 1'b1, 0);

    // Both valid: LS first, IF in the IDLE cycle right after LS's response.
    if_addr = 64'h8000_0004;
    v = '{1, 64'h8000_1000, 0, 64'd0, 8'h00, 0, 0, 64'hAAAA_0001, 0};
    run_txn(v, 1'b1, 1'b1, 0);
    v = '{0, 64'h8000_0004, 0, 64'd0, 8'h00, 0, 0, 64'hBBBB_0002, 0};
    run_txn(v, 1'b0, 1'b1, 0);

    // Both held valid: grants must follow LS,LS,LS,LS,IF repeating.
    if_addr = 64'h8000_0040;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) v = '{0, 64'h8000_0040, 0, 64'd0, 8'h00, 0, 0, 64'h1000 + k, 0};
      else            v = '{1, 64'h8000_3000, 0, 64'd0, 8'h00, 0, 0, 64'h2000 + k, 0};
      run_txn(v, 1'b1, 1'b1, 0);
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;

    // Stray responses while idle.
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) begin
      @(negedge clk);
      check("stray_busy", {63'd0, busy}, 64'd0);
      check("stray_rsp", {62'd0, if_rsp_valid, ls_rsp_valid}, 64'd0);
      check("stray_if_rdata", if_rdata, last_if);
      check("stray_ls_rdata", ls_rdata, last_ls);
    end
    mem_rsp_valid = 1'b0;

    // Reset while waiting for memory drops the transaction.
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr      = 64'h8000_0100;
    #1;
    check("pre_rst_grant", {63'd0, if_req_ready}, 64'd1);
    @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_wait", {62'd0, busy, mem_req_valid}, 64'd2);
    rst = 1'b1;
    ls_req_valid = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_mem_addr", mem_addr, 64'd0);
    check("arst_mem_fields", {mem_wdata[62:0], mem_wen} | {56'd0, mem_wmask}, 64'd0);
    check("arst_rdata", if_rdata | ls_rdata, 64'd0);
    check("arst_ready", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    sb.delete();
    last_if = '0;
    last_ls = '0;
    @(posedge clk);
    @(negedge clk);
    ls_req_valid  = 1'b0;
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hDEAD_0000_DEAD_0000;
    v = '{0, 64'h8000_0200, 0, 64'd0, 8'h00, 1, 1, 64'h0000_0093, 0};
    run_txn(v, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
